// File: rtl/imc_tx_scheduler_if.sv
// rtl/imc_tx_scheduler_if.sv - requester and tx_module signal bundle for the IMC transmit scheduler
interface imc_tx_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    ack;
    logic [N_REQ-1:0]    fail;
    logic                bus_idle;
    logic                Tx_En_Sig;
    logic [31:0]         Tx_Data;
    logic                Tx_Done_Sig;
    logic                Tx_Cancel;

    modport master (
        input  req, req_data, bus_idle, Tx_Done_Sig, Tx_Cancel,
        output ack, fail, Tx_En_Sig, Tx_Data
    );

    modport slave (
        output req, req_data, bus_idle, Tx_Done_Sig, Tx_Cancel,
        input  ack, fail, Tx_En_Sig, Tx_Data
    );
endinterface

// File: rtl/imc_tx_scheduler.sv
// rtl/imc_tx_scheduler.sv - round-robin sharing of the IMC transmitter with period gating and retry backoff
module imc_tx_scheduler #(
    parameter int N_REQ        = 4,
    parameter int PERIOD       = 20000,
    parameter int BACKOFF_UNIT = 100,
    parameter int MAX_RETRY    = 7,
    parameter int TIMEOUT      = 8000
) (
    input  logic                clk_100,
    input  logic                RSTn,
    input  logic                imc_enable,
    imc_tx_scheduler_if.master  bus,
    output logic                busy,
    output logic [3:0]          cur_id
);
    typedef enum logic [1:0] {IDLE, WAIT_BUS, SEND, BACKOFF} state_t;

    localparam logic [15:0] PERIOD_M1  = 16'(PERIOD - 1);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
    localparam logic [15:0] BO_UNIT    = 16'(BACKOFF_UNIT);
    localparam logic [3:0]  MAX_R      = 4'(MAX_RETRY);
    localparam logic [3:0]  LAST_ID    = 4'(N_REQ - 1);

    state_t      state;
    logic [3:0]  rr_ptr;
    logic [3:0]  retry;
    logic [15:0] period_cnt;
    logic [15:0] timeout_cnt;
    logic [15:0] bo_cnt;

    logic [15:0] req_pad;
    logic [3:0]  winner;
    logic [31:0] win_data;
    logic        found;
    logic [4:0]  idx;
    logic [15:0] bo_load;
    logic [3:0]  next_ptr;

    // First set request at or after rr_ptr, wrapping at N_REQ
    always_comb begin
        req_pad  = 16'(bus.req);
        winner   = rr_ptr;
        found    = 1'b0;
        idx      = 5'd0;
        win_data = 32'd0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, rr_ptr} + 5'(i);
            if (idx >= 5'(N_REQ)) idx = idx - 5'(N_REQ);
            if (!found && req_pad[idx[3:0]]) begin
                winner = idx[3:0];
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == 4'(i)) win_data = bus.req_data[32*i +: 32];
        end
    end

    assign bo_load  = ({12'd0, retry} + 16'd1) * BO_UNIT - 16'd1;
    assign next_ptr = (cur_id == LAST_ID) ? 4'd0 : cur_id + 4'd1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk_100 or negedge RSTn) begin
        if (!RSTn) begin
            state         <= IDLE;
            rr_ptr        <= 4'd0;
            retry         <= 4'd0;
            period_cnt    <= 16'd0;
            timeout_cnt   <= 16'd0;
            bo_cnt        <= 16'd0;
            cur_id        <= 4'd0;
            bus.ack       <= '0;
            bus.fail      <= '0;
            bus.Tx_En_Sig <= 1'b0;
            bus.Tx_Data   <= 32'd0;
        end else begin
            bus.ack  <= '0;
            bus.fail <= '0;
            if (period_cnt != 16'd0) period_cnt <= period_cnt - 16'd1;
            case (state)
                // Leave IDLE one count early: the WAIT_BUS cycle consumes the last period tick
                IDLE: if (imc_enable && (|bus.req) && period_cnt <= 16'd1) begin
                    state       <= WAIT_BUS;
                    cur_id      <= winner;
                    bus.Tx_Data <= win_data;
                    retry       <= 4'd0;
                end
                WAIT_BUS: if (bus.bus_idle) begin
                    state         <= SEND;
                    bus.Tx_En_Sig <= 1'b1;
                    period_cnt    <= PERIOD_M1;
                    timeout_cnt   <= 16'd0;
                end
                SEND: begin
                    timeout_cnt <= timeout_cnt + 16'd1;
                    if (bus.Tx_Done_Sig) begin
                        bus.ack       <= N_REQ'(16'd1 << cur_id);
                        bus.Tx_En_Sig <= 1'b0;
                        rr_ptr        <= next_ptr;
                        state         <= IDLE;
                    end else if (bus.Tx_Cancel && retry < MAX_R) begin
                        bus.Tx_En_Sig <= 1'b0;
                        retry         <= retry + 4'd1;
                        bo_cnt        <= bo_load;
                        state         <= BACKOFF;
                    end else if (bus.Tx_Cancel || timeout_cnt == TIMEOUT_M1) begin
                        bus.fail      <= N_REQ'(16'd1 << cur_id);
                        bus.Tx_En_Sig <= 1'b0;
                        rr_ptr        <= next_ptr;
                        state         <= IDLE;
                    end
                end
                BACKOFF: begin
                    if (bo_cnt == 16'd0) state <= WAIT_BUS;
                    else                 bo_cnt <= bo_cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imc_tx_scheduler.sv
// tb/tb_imc_tx_scheduler.sv - directed self-checking bench for imc_tx_scheduler
module tb_imc_tx_scheduler;
    localparam int N_REQ   = 4;
    localparam int PERIOD  = 400;
    localparam int BO_UNIT = 100;
    localparam int MAX_RTY = 7;
    localparam int TMO     = 300;

    logic       clk_100 = 1'b0;
    logic       RSTn;
    logic       imc_enable;
    logic       busy;
    logic [3:0] cur_id;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [31:0] exp_word [4];

    imc_tx_scheduler_if #(.N_REQ(N_REQ)) bus ();

    imc_tx_scheduler #(
        .N_REQ(N_REQ), .PERIOD(PERIOD), .BACKOFF_UNIT(BO_UNIT),
        .MAX_RETRY(MAX_RTY), .TIMEOUT(TMO)
    ) dut (
        .clk_100(clk_100), .RSTn(RSTn), .imc_enable(imc_enable),
        .bus(bus), .busy(busy), .cur_id(cur_id)
    );

    always #5 clk_100 = ~clk_100;
    always @(posedge clk_100) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic wait_en(input logic v, input int budget, input string tag);
        int n = 0;
        while (bus.Tx_En_Sig !== v && n < budget) begin
            tick();
            n++;
        end
        if (bus.Tx_En_Sig !== v) chk(tag, {31'd0, bus.Tx_En_Sig}, {31'd0, v});
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        bus.req = '0;
        bus.Tx_Done_Sig = 1'b0;
        bus.Tx_Cancel = 1'b0;
        repeat (3) tick();
        RSTn = 1'b1;
        tick();
    endtask

    task automatic pulse(input logic done, input logic cancel);
        bus.Tx_Done_Sig = done;
        bus.Tx_Cancel   = cancel;
        tick();
        bus.Tx_Done_Sig = 1'b0;
        bus.Tx_Cancel   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, prev, f, r, n;
        exp_word[0] = 32'hA000_0000;
        exp_word[1] = 32'hB000_0011;
        exp_word[2] = 32'hC000_0022;
        exp_word[3] = 32'hD000_0033;
        bus.req_data = {exp_word[3], exp_word[2], exp_word[1], exp_word[0]};
        bus.bus_idle = 1'b1;
        imc_enable = 1'b1;
        bus.req = '0;
        bus.Tx_Done_Sig = 1'b0;
        bus.Tx_Cancel = 1'b0;
        RSTn = 1'b0;
        tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_en", {31'd0, bus.Tx_En_Sig}, 0);
        chk("rst_data", bus.Tx_Data, 0);
        chk("rst_id", {28'd0, cur_id}, 0);
        chk("rst_ackfail", {24'd0, bus.ack, bus.fail}, 0);

        // single request, 2-cycle latency, ack after Done
        do_reset();
        bus.req = 4'b0001;
        tick();
        chk("t1_wait_en", {31'd0, bus.Tx_En_Sig}, 0);
        chk("t1_wait_busy", {31'd0, busy}, 1);
        tick();
        chk("t1_en", {31'd0, bus.Tx_En_Sig}, 1);
        chk("t1_data", bus.Tx_Data, exp_word[0]);
        repeat (49) tick();
        chk("t1_hold", bus.Tx_Data, exp_word[0]);
        pulse(1'b1, 1'b0);
        chk("t1_ack", {28'd0, bus.ack}, 4'b0001);
        chk("t1_en_off", {31'd0, bus.Tx_En_Sig}, 0);
        bus.req = '0;
        tick();
        chk("t1_ack_end", {28'd0, bus.ack}, 0);
        chk("t1_idle", {31'd0, busy}, 0);

        // round robin over all requesters, period spacing
        do_reset();
        bus.req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_en(1'b1, PERIOD + 20, "t2_rise");
            t = cyc;
            if (k > 0) chk("t2_gap", t - prev, PERIOD);
            prev = t;
            chk("t2_id", {28'd0, cur_id}, k % 4);
            chk("t2_data", bus.Tx_Data, exp_word[k % 4]);
            repeat (5) tick();
            pulse(1'b1, 1'b0);
            chk("t2_ack", {28'd0, bus.ack}, 32'd1 << (k % 4));
        end
        bus.req = '0;

        // two cancels with linear backoff, then Done
        do_reset();
        bus.req = 4'b0001;
        wait_en(1'b1, 10, "t3_rise0");
        for (int k = 1; k <= 2; k++) begin
            repeat (3) tick();
            pulse(1'b0, 1'b1);
            chk("t3_fall", {31'd0, bus.Tx_En_Sig}, 0);
            f = cyc;
            bus.req_data[31:0] = 32'h1234_5678;
            wait_en(1'b1, 400, "t3_rise");
            chk("t3_gap", cyc - f, k * BO_UNIT + 1);
            chk("t3_data", bus.Tx_Data, exp_word[0]);
            bus.req_data[31:0] = exp_word[0];
        end
        pulse(1'b1, 1'b0);
        chk("t3_ack", {28'd0, bus.ack}, 4'b0001);
        bus.req = '0;

        // cancel on every attempt: 8 attempts then fail, pointer advances
        do_reset();
        bus.req = 4'b0010;
        for (int a = 0; a < 8; a++) begin
            wait_en(1'b1, 1000, "t4_rise");
            repeat (2) tick();
            pulse(1'b0, 1'b1);
            if (a < 7) chk("t4_nofail", {28'd0, bus.fail}, 0);
            else       chk("t4_fail", {28'd0, bus.fail}, 4'b0010);
        end
        chk("t4_idle", {31'd0, busy}, 0);
        bus.req = '0;
        tick();
        chk("t4_fail_end", {28'd0, bus.fail}, 0);
        repeat (PERIOD) tick();
        bus.req = 4'b0011;
        wait_en(1'b1, 20, "t4_rise2");
        chk("t4_rr", {28'd0, cur_id}, 0);
        pulse(1'b1, 1'b0);
        chk("t4_ack", {28'd0, bus.ack}, 4'b0001);
        bus.req = '0;

        // timeout in SEND
        do_reset();
        bus.req = 4'b0100;
        wait_en(1'b1, 10, "t5_rise");
        r = cyc;
        n = 0;
        while (bus.fail == '0 && n < TMO + 20) begin
            tick();
            n++;
        end
        chk("t5_fail", {28'd0, bus.fail}, 4'b0100);
        chk("t5_when", cyc - r, TMO);
        chk("t5_en", {31'd0, bus.Tx_En_Sig}, 0);
        bus.req = '0;

        // Done and Cancel together: Done wins
        do_reset();
        bus.req = 4'b1000;
        wait_en(1'b1, 10, "t6_rise");
        repeat (2) tick();
        pulse(1'b1, 1'b1);
        chk("t6_ack", {28'd0, bus.ack}, 4'b1000);
        chk("t6_nofail", {28'd0, bus.fail}, 0);
        chk("t6_idle", {31'd0, busy}, 0);
        bus.req = '0;

        // asynchronous reset mid-SEND restarts arbitration at 0
        do_reset();
        bus.req = 4'b0001;
        wait_en(1'b1, 10, "t7_rise0");
        pulse(1'b1, 1'b0);
        bus.req = '0;
        repeat (PERIOD) tick();
        bus.req = 4'b0011;
        wait_en(1'b1, 20, "t7_rise1");
        chk("t7_id1", {28'd0, cur_id}, 1);
        #2 RSTn = 1'b0;
        #1;
        chk("t7_en_async", {31'd0, bus.Tx_En_Sig}, 0);
        chk("t7_busy_async", {31'd0, busy}, 0);
        repeat (2) tick();
        RSTn = 1'b1;
        wait_en(1'b1, 20, "t7_rise2");
        chk("t7_id0", {28'd0, cur_id}, 0);
        chk("t7_data", bus.Tx_Data, exp_word[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
